// File: rtl/msx_clken_sequencer.sv
// Clock-enable sequencer for the MSX side: boot reset hold-off, CPU/PSG enables,
// glitch-free turbo switching and a pause handshake for the SD/loader master.
module msx_clken_sequencer #(
    parameter int STARTUP_CYCLES = 1024,
    parameter int DIV_NORMAL     = 5,
    parameter int DIV_TURBO      = 2,
    parameter int CNT_W          = 4
) (
    input  logic       i_CLK,
    input  logic       i_RST_n,
    input  logic       i_TURBO_REQ,
    input  logic       i_HOLD,
    output logic       o_SYS_RST_n,
    output logic       o_CPU_CE,
    output logic       o_PSG_CE,
    output logic       o_TURBO_ACT,
    output logic       o_HOLD_ACK,
    output logic [1:0] o_STATE
);

    localparam int BOOT_W = $clog2(STARTUP_CYCLES);
    localparam logic [BOOT_W-1:0] BOOT_LAST   = BOOT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LAST_NORMAL = CNT_W'(DIV_NORMAL - 1);
    localparam logic [CNT_W-1:0]  LAST_TURBO  = CNT_W'(DIV_TURBO - 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [BOOT_W-1:0] boot_cnt_reg, boot_cnt_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              psg_ph_reg, psg_ph_next;
    logic              turbo_meta_reg, turbo_sync_reg;
    logic              turbo_act_reg, turbo_act_next;
    logic              sys_rst_n_reg, sys_rst_n_next;
    logic              cpu_ce_reg, cpu_ce_next;
    logic              psg_ce_reg, psg_ce_next;
    logic              hold_ack_reg, hold_ack_next;
    logic [CNT_W-1:0]  cnt_last;
    logic              wrap;

    // The divisor only changes on a wrap, so the period in flight is never cut short.
    assign cnt_last = turbo_act_reg ? LAST_TURBO : LAST_NORMAL;
    assign wrap     = (cnt_reg == cnt_last);

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_reg      <= ST_BOOT;
            boot_cnt_reg   <= '0;
            cnt_reg        <= '0;
            psg_ph_reg     <= 1'b0;
            turbo_meta_reg <= 1'b0;
            turbo_sync_reg <= 1'b0;
            turbo_act_reg  <= 1'b0;
            sys_rst_n_reg  <= 1'b0;
            cpu_ce_reg     <= 1'b0;
            psg_ce_reg     <= 1'b0;
            hold_ack_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            boot_cnt_reg   <= boot_cnt_next;
            cnt_reg        <= cnt_next;
            psg_ph_reg     <= psg_ph_next;
            turbo_meta_reg <= i_TURBO_REQ;
            turbo_sync_reg <= turbo_meta_reg;
            turbo_act_reg  <= turbo_act_next;
            sys_rst_n_reg  <= sys_rst_n_next;
            cpu_ce_reg     <= cpu_ce_next;
            psg_ce_reg     <= psg_ce_next;
            hold_ack_reg   <= hold_ack_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        boot_cnt_next  = boot_cnt_reg;
        cnt_next       = cnt_reg;
        psg_ph_next    = psg_ph_reg;
        turbo_act_next = turbo_act_reg;
        sys_rst_n_next = sys_rst_n_reg;
        cpu_ce_next    = 1'b0;
        psg_ce_next    = 1'b0;
        hold_ack_next  = hold_ack_reg;

        case (state_reg)
            ST_BOOT: begin
                if (boot_cnt_reg == BOOT_LAST) begin
                    state_next     = ST_RUN;
                    sys_rst_n_next = 1'b1;
                    cnt_next       = '0;
                end else begin
                    boot_cnt_next = boot_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (wrap) begin
                    cnt_next       = '0;
                    cpu_ce_next    = 1'b1;
                    psg_ce_next    = psg_ph_reg;
                    psg_ph_next    = ~psg_ph_reg;
                    turbo_act_next = turbo_sync_reg;
                    // Pause is only granted on a period boundary; this wrap's enable still goes out.
                    if (i_HOLD) begin
                        state_next    = ST_HOLD;
                        hold_ack_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_HOLD: begin
                cnt_next = '0;
                if (!i_HOLD) begin
                    state_next    = ST_RUN;
                    hold_ack_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    assign o_SYS_RST_n = sys_rst_n_reg;
    assign o_CPU_CE    = cpu_ce_reg;
    assign o_PSG_CE    = psg_ce_reg;
    assign o_TURBO_ACT = turbo_act_reg;
    assign o_HOLD_ACK  = hold_ack_reg;
    assign o_STATE     = state_reg;

endmodule

// File: tb/tb_msx_clken_sequencer.sv
// Directed bench for msx_clken_sequencer: boot, enable periods, turbo switching,
// pause handshake and asynchronous reset, with hand-computed cycle counts.
module tb_msx_clken_sequencer;

    localparam int STARTUP = 16;

    logic       clk;
    logic       rst_n;
    logic       turbo;
    logic       hold;
    logic       sys_rst_n;
    logic       cpu_ce;
    logic       psg_ce;
    logic       turbo_act;
    logic       hold_ack;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    msx_clken_sequencer #(
        .STARTUP_CYCLES(STARTUP),
        .DIV_NORMAL    (5),
        .DIV_TURBO     (2),
        .CNT_W         (4)
    ) dut (
        .i_CLK      (clk),
        .i_RST_n    (rst_n),
        .i_TURBO_REQ(turbo),
        .i_HOLD     (hold),
        .o_SYS_RST_n(sys_rst_n),
        .o_CPU_CE   (cpu_ce),
        .o_PSG_CE   (psg_ce),
        .o_TURBO_ACT(turbo_act),
        .o_HOLD_ACK (hold_ack),
        .o_STATE    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] outs_vec();
        return {25'd0, sys_rst_n, cpu_ce, psg_ce, turbo_act, hold_ack, state};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Count negedges until the next CPU enable is seen (bounded) and compare the distance.
    task automatic wait_ce(input string tag, input int exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ce && n < 40);
        $display("%s: cpu_ce after %0d cycles psg_ce=%0b turbo_act=%0b hold_ack=%0b",
                 tag, n, psg_ce, turbo_act, hold_ack);
        check(tag, 32'(n), 32'(exp));
    endtask

    task automatic boot_check(input string tag);
        for (int k = 1; k <= STARTUP; k++) begin
            @(negedge clk);
            if (k < STARTUP)
                check({tag, "_quiet"}, 32'({sys_rst_n, cpu_ce, psg_ce, hold_ack}), 32'd0);
        end
        $display("%s: reset released, state=%0d", tag, state);
        check({tag, "_release"}, 32'(sys_rst_n), 32'd1);
        check({tag, "_state"}, 32'(state), 32'd1);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check(tag, outs_vec(), 32'd0);
        $display("%s: outputs after async reset = %0h", tag, outs_vec());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        turbo = 1'b0;
        hold  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs_vec(), 32'd0);
        rst_n = 1'b1;

        // Boot, then first CE 5 cycles after reset release
        boot_check("boot1");
        wait_ce("first_ce", 5);
        check("first_ce_psg", 32'(psg_ce), 32'd0);

        // Normal-mode period and PSG on every 2nd CPU enable
        wait_ce("norm_ce2", 5);
        check("norm_ce2_psg", 32'(psg_ce), 32'd1);
        wait_ce("norm_ce3", 5);
        check("norm_ce3_psg", 32'(psg_ce), 32'd0);
        wait_ce("norm_ce4", 5);
        check("norm_ce4_psg", 32'(psg_ce), 32'd1);

        // Turbo request mid-period: current period of 5 completes, then period 2
        repeat (2) @(negedge clk);
        turbo = 1'b1;
        wait_ce("turbo_on_finish", 3);
        check("turbo_on_act", 32'(turbo_act), 32'd1);
        check("turbo_on_psg", 32'(psg_ce), 32'd0);
        wait_ce("turbo_p1", 2);
        check("turbo_p1_psg", 32'(psg_ce), 32'd1);
        wait_ce("turbo_p2", 2);

        // Turbo release: one more turbo period while the synchroniser catches up
        turbo = 1'b0;
        wait_ce("turbo_off_p1", 2);
        check("turbo_off_act_still", 32'(turbo_act), 32'd1);
        wait_ce("turbo_off_p2", 2);
        check("turbo_off_act", 32'(turbo_act), 32'd0);
        wait_ce("normal_again", 5);
        check("normal_again_psg", 32'(psg_ce), 32'd1);

        // Pause requested at cnt=1: granted at the wrap, which still issues its CE
        @(negedge clk);
        hold = 1'b1;
        @(negedge clk);
        check("hold_not_yet", 32'(hold_ack), 32'd0);
        wait_ce("hold_entry_ce", 3);
        check("hold_entry", 32'({hold_ack, state}), 32'b110);
        check("hold_entry_psg", 32'(psg_ce), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("hold_quiet", 32'({cpu_ce, psg_ce, hold_ack}), 32'b001);
        end
        hold = 1'b0;
        @(negedge clk);
        check("hold_exit", 32'({hold_ack, state}), 32'b001);
        wait_ce("hold_exit_ce", 5);
        check("hold_exit_psg", 32'(psg_ce), 32'd1);

        // Turbo change and pause land on the same wrap; turbo period after release
        turbo = 1'b1;
        hold  = 1'b1;
        wait_ce("combo_entry", 5);
        check("combo_entry_flags", 32'({hold_ack, turbo_act, state}), 32'b1110);
        repeat (3) @(negedge clk);
        check("combo_hold_quiet", 32'(cpu_ce), 32'd0);
        hold = 1'b0;
        wait_ce("combo_exit", 3);
        check("combo_exit_psg", 32'(psg_ce), 32'd1);
        wait_ce("combo_turbo", 2);

        // Reset mid-RUN: outputs drop without a clock edge, full boot repeats
        async_reset("rst_mid_run");
        boot_check("boot2");
        wait_ce("boot2_first_ce", 5);
        check("boot2_turbo_loaded", 32'(turbo_act), 32'd1);
        check("boot2_psg", 32'(psg_ce), 32'd0);
        wait_ce("boot2_turbo", 2);

        // Reset mid-HOLD; pause request is ignored while booting
        hold = 1'b1;
        wait_ce("hold2_entry", 2);
        check("hold2_state", 32'({hold_ack, state}), 32'b110);
        async_reset("rst_mid_hold");
        boot_check("boot3");
        hold  = 1'b0;
        turbo = 1'b0;
        wait_ce("boot3_first_ce", 5);
        check("boot3_turbo", 32'(turbo_act), 32'd0);
        wait_ce("boot3_normal", 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
